df_controller_mc: RTL



---
 rtl/df_ctrl_pkg.sv | 19 +
 rtl/df_controller_mc.sv | 113 +++++++++++
 2 files changed

// File: rtl/df_ctrl_pkg.sv
// Shared definitions for the dataflow actor controllers: actor return codes and FSM state encoding.
package df_ctrl_pkg;

  localparam logic [31:0] RET_IDLE           = 32'd0;
  localparam logic [31:0] RET_WAIT_PREDICATE = 32'd1;
  localparam logic [31:0] RET_WAIT_INPUT     = 32'd2;
  localparam logic [31:0] RET_WAIT_OUTPUT    = 32'd3;
  localparam logic [31:0] RET_WAIT_GUARD     = 32'd4;
  localparam logic [31:0] RET_EXECUTED       = 32'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_EVAL      = 3'd3,
    ST_WAIT_IN   = 3'd4
  } state_e;

endpackage

// File: rtl/df_controller_mc.sv
// Multi-input dataflow actor controller: launches an ap_ctrl_hs core repeatedly and
// uses the registered return code to re-fire, wait for input, retry, or go idle.
//
// state     | meaning
// IDLE      | nothing running, waiting for ap_start
// START     | core_start high until the core accepts it
// WAIT_DONE | core running, waiting for core_done
// EVAL      | one cycle deciding on ret_q
// WAIT_IN   | actor reported missing input, waiting for a masked port
module df_controller_mc
  import df_ctrl_pkg::*;
#(
  parameter int unsigned           NUM_INPUTS  = 1,
  parameter int unsigned           RET_W       = 32,
  parameter logic [NUM_INPUTS-1:0] INPUT_MASK  = '1,
  parameter int unsigned           MAX_RETRIES = 0,
  parameter int unsigned           CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ap_start,
  output logic                  core_start,
  input  logic                  core_ready,
  input  logic                  core_done,
  input  logic [RET_W-1:0]      core_return,
  input  logic [NUM_INPUTS-1:0] available_data,
  input  logic                  others_executing,
  output logic                  executing,
  output logic                  idle,
  output logic [CNT_W-1:0]      fire_count
);

  localparam int unsigned RC_W = (MAX_RETRIES == 0) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [RC_W-1:0] RETRY_LIMIT = (MAX_RETRIES == 0) ? '1 : RC_W'(MAX_RETRIES);

  state_e            state_q, state_d;
  logic [RET_W-1:0]  ret_q, ret_d;
  logic [RC_W-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0]  fire_q, fire_d;
  logic              avail;
  logic              retry_ok;

  assign avail    = |(available_data & INPUT_MASK);
  assign retry_ok = (MAX_RETRIES == 0) || (retry_q < RETRY_LIMIT);

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    retry_d = retry_q;
    fire_d  = fire_q;
    case (state_q)
      ST_IDLE: if (ap_start) state_d = ST_START;
      ST_START: begin
        if (core_ready) begin
          if (core_done) begin
            ret_d   = core_return;
            state_d = ST_EVAL;
          end else begin
            state_d = ST_WAIT_DONE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (core_done) begin
          ret_d   = core_return;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (ret_q == RET_W'(RET_EXECUTED)) begin
          if (fire_q != '1) fire_d = fire_q + CNT_W'(1);
          retry_d = '0;
          state_d = ap_start ? ST_START : ST_IDLE;
        end else if (ret_q == RET_W'(RET_WAIT_INPUT)) begin
          retry_d = '0;
          state_d = ST_WAIT_IN;
        end else if (ap_start && (avail || others_executing) && retry_ok) begin
          // Unbounded mode saturates rather than wrapping back to zero.
          if (retry_q != '1) retry_d = retry_q + RC_W'(1);
          state_d = ST_START;
        end else begin
          retry_d = '0;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_IN: begin
        if (avail && ap_start) state_d = ST_START;
        else if (!avail && (!ap_start || !others_executing)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ret_q   <= '0;
      retry_q <= '0;
      fire_q  <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      retry_q <= retry_d;
      fire_q  <= fire_d;
    end
  end

  assign core_start = (state_q == ST_START);
  assign executing  = (state_q == ST_START) || (state_q == ST_WAIT_DONE) || (state_q == ST_EVAL);
  assign idle       = (state_q == ST_IDLE);
  assign fire_count = fire_q;

endmodule
